// File: rtl/clus_ctrl_pkg.sv
// clus_ctrl_pkg
//   Shared definitions for the cluster sequencer.
//   - clus_state_t : sequencer state encoding. IDLE is all-zero, so a cleared
//                    state register reads as IDLE on the debug port.
//   - READ_LAT     : psum GLB read latency in cycles. This is the length of RD_WAIT.
//   - cnt_bits     : width of a counter that must hold values 0..max_count.
package clus_ctrl_pkg;

  localparam int READ_LAT = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD_W   = 4'd1,
    ST_LOAD_A   = 4'd2,
    ST_SPAD     = 4'd3,
    ST_WAIT_LD  = 4'd4,
    ST_WAIT_CMP = 4'd5,
    ST_RD_REQ   = 4'd6,
    ST_RD_WAIT  = 4'd7,
    ST_OUT      = 4'd8,
    ST_FIN      = 4'd9
  } clus_state_t;

  function automatic int cnt_bits(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/clus_out_reg.sv
// clus_out_reg
//   Holding register for the psum result stream.
//   Ports:
//     clk, reset     : clock and synchronous active-low reset
//     load/load_data : capture a new word; this raises out_valid on the next cycle
//     out_ready      : consumer accept
//     out_valid/out_data : registered stream output
//   Handshake: a word transfers on a cycle with out_valid && out_ready. While
//   out_valid is high and out_ready is low, out_data does not change. The
//   sequencer issues load only while out_valid is low.
module clus_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/clus_ctrl.sv
// clus_ctrl
//   Sequencer for one processing cluster. The sequencer runs these steps in order:
//   1. Write the host word stream into the weight GLB, then into the activation GLB.
//   2. Pulse the spad-load controls.
//   3. Wait for load_done, then pulse start.
//   4. Wait for compute_done. A timeout here sets the sticky error.
//   5. Read each psum, one word at a time, and stream it out.
//   Ports:
//     clk, reset (sync, active-low), job_start -> busy, job_done, error
//     in_valid/in_ready/in_data    : host load stream
//     out_valid/out_ready/out_data : psum result stream
//     write_en_*/w_addr_*/w_data_* : GLB writes (combinational pass-through of in_data)
//     load_spad_ctrl_*, start      : cluster control pulses
//     load_done, compute_done      : cluster status
//     read_req_psum/r_addr_psum/r_data_psum : psum GLB read, data READ_LAT cycles later
//     dbg_state                    : current sequencer state
//   All outputs are forced to 0 while reset is low.
module clus_ctrl
  import clus_ctrl_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int W_COUNT       = 9,
  parameter int A_COUNT       = 25,
  parameter int P_COUNT       = 9,
  parameter int W_BASE        = 0,
  parameter int A_BASE        = 0,
  parameter int P_BASE        = 0,
  parameter int CMP_TIMEOUT   = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_start,
  output logic                     busy,
  output logic                     job_done,
  output logic                     error,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     write_en_wght,
  output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
  output logic [DATA_BITWIDTH-1:0] w_data_wght,
  output logic                     write_en_iact,
  output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
  output logic [DATA_BITWIDTH-1:0] w_data_iact,
  output logic                     load_spad_ctrl_wght,
  output logic                     load_spad_ctrl_iact,
  output logic                     start,
  input  logic                     load_done,
  input  logic                     compute_done,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output clus_state_t              dbg_state
);

  localparam int CW = cnt_bits((W_COUNT > A_COUNT) ? W_COUNT : A_COUNT);
  localparam int PW = cnt_bits(P_COUNT);
  localparam int TW = cnt_bits(CMP_TIMEOUT);
  localparam int LW = cnt_bits(READ_LAT);

  clus_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          error_q, error_d;
  logic          start_q, start_d;
  logic          cap;
  logic          ov;
  logic [DATA_BITWIDTH-1:0] od;

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    pcnt_d              = pcnt_q;
    timer_d             = timer_q;
    lat_d               = lat_q;
    error_d             = error_q;
    start_d             = 1'b0;
    cap                 = 1'b0;
    in_ready            = 1'b0;
    write_en_wght       = 1'b0;
    w_addr_wght         = '0;
    w_data_wght         = '0;
    write_en_iact       = 1'b0;
    w_addr_iact         = '0;
    w_data_iact         = '0;
    load_spad_ctrl_wght = 1'b0;
    load_spad_ctrl_iact = 1'b0;
    read_req_psum       = 1'b0;
    r_addr_psum         = '0;
    job_done            = 1'b0;
    // Outputs stay at their zero defaults while reset is held.
    if (reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (job_start) begin
            state_d = ST_LOAD_W;
            error_d = 1'b0;
            cnt_d   = '0;
            pcnt_d  = '0;
            timer_d = '0;
            lat_d   = '0;
          end
        end
        ST_LOAD_W: begin
          in_ready = 1'b1;
          if (in_valid) begin
            write_en_wght = 1'b1;
            w_addr_wght   = ADDR_BITWIDTH'(W_BASE + int'(cnt_q));
            w_data_wght   = in_data;
            if (cnt_q == CW'(W_COUNT - 1)) begin
              cnt_d   = '0;
              state_d = ST_LOAD_A;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_LOAD_A: begin
          in_ready = 1'b1;
          if (in_valid) begin
            write_en_iact = 1'b1;
            w_addr_iact   = ADDR_BITWIDTH'(A_BASE + int'(cnt_q));
            w_data_iact   = in_data;
            if (cnt_q == CW'(A_COUNT - 1)) begin
              cnt_d   = '0;
              state_d = ST_SPAD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_SPAD: begin
          load_spad_ctrl_wght = 1'b1;
          load_spad_ctrl_iact = 1'b1;
          state_d             = ST_WAIT_LD;
        end
        ST_WAIT_LD: begin
          // start is registered, so it is high in the first WAIT_CMP cycle.
          if (load_done) begin
            start_d = 1'b1;
            timer_d = '0;
            state_d = ST_WAIT_CMP;
          end
        end
        ST_WAIT_CMP: begin
          // compute_done has priority over the timeout. A level that is
          // already high on entry is accepted in the first cycle.
          if (compute_done) begin
            pcnt_d  = '0;
            state_d = ST_RD_REQ;
          end else if (timer_q == TW'(CMP_TIMEOUT)) begin
            error_d = 1'b1;
            state_d = ST_FIN;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_RD_REQ: begin
          read_req_psum = 1'b1;
          r_addr_psum   = ADDR_BITWIDTH'(P_BASE + int'(pcnt_q));
          lat_d         = '0;
          state_d       = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (lat_q == LW'(READ_LAT - 1)) begin
            cap     = 1'b1;
            state_d = ST_OUT;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (ov && out_ready) begin
            pcnt_d  = pcnt_q + 1'b1;
            state_d = (pcnt_q == PW'(P_COUNT - 1)) ? ST_FIN : ST_RD_REQ;
          end
        end
        ST_FIN: begin
          job_done = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      timer_q <= '0;
      lat_q   <= '0;
      error_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      timer_q <= timer_d;
      lat_q   <= lat_d;
      error_q <= error_d;
      start_q <= start_d;
    end
  end

  clus_out_reg #(.W(DATA_BITWIDTH)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (cap),
    .load_data (r_data_psum),
    .out_ready (out_ready),
    .out_valid (ov),
    .out_data  (od)
  );

  assign busy      = reset && (state_q != ST_IDLE);
  assign error     = reset && error_q;
  assign start     = reset && start_q;
  assign out_valid = reset && ov;
  assign out_data  = reset ? od : '0;
  assign dbg_state = state_q;

endmodule
